// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: streams the index of every set bit of an accepted vector, lowest first
module onehot_encoder_seq #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d_valid,
    output logic         d_ready,
    input  logic [N-1:0] d,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [W-1:0] y,
    output logic         y_last,
    output logic         zero_err,
    output logic         busy
);
    typedef enum logic {IDLE, OUT} state_t;
    state_t state;
    logic [N-1:0] pending;
    assign d_ready = state == IDLE;
    assign y_valid = state == OUT;
    assign busy = state == OUT;
    assign y_last = y_valid && pending != '0 && (pending & (pending - N'(1))) == '0;
    always_comb begin
        y = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pending[i]) y = W'(i);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pending <= '0;
            zero_err <= 1'b0;
        end else begin
            zero_err <= state == IDLE && d_valid && d == '0;
            if (state == IDLE && d_valid && d != '0) begin
                pending <= d;
                state <= OUT;
            end else if (state == OUT && y_ready) begin
                pending <= pending & (pending - N'(1));
                if (y_last) state <= IDLE;
            end
        end
    end
endmodule
